// File: rtl/ps2_pkg.sv
// PS/2 keyboard receiver shared definitions.
// FSM encoding, frame constants and parameter defaults.
package ps2_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    localparam int TIMEOUT_DEF    = 50000;
    localparam int DEPTH_LOG2_DEF = 3;

    // Odd parity holds when data plus parity bit has an odd number of ones.
    function automatic logic odd_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_keyb_if.sv
// CPU-side bus of the PS/2 keyboard receiver.
// The CPU drives the pop strobe; the receiver returns data and status.
interface ps2_keyb_if;
    import ps2_pkg::*;

    logic       rd;
    logic [7:0] data;
    logic       ready;
    logic       irq;
    logic       ovf;
    logic       perr;

    modport master (
        output rd,
        input  data,
        input  ready,
        input  irq,
        input  ovf,
        input  perr
    );

    modport slave (
        input  rd,
        output data,
        output ready,
        output irq,
        output ovf,
        output perr
    );

endinterface

// File: rtl/ps2_fifo.sv
// First-word fall-through receive FIFO for scan-code bytes.
// A pop on a full FIFO frees the slot for a same-cycle push.
module ps2_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]          mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  do_pop;
    logic                  do_push;

    assign empty   = (cnt_q == '0);
    assign full    = cnt_q[DEPTH_LOG2];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? 8'h00 : mem_q[rd_ptr_q];

    // Pointer and occupancy update from the qualified push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/ps2_keyb.sv
// PS/2 keyboard receiver: synchronizers, frame FSM, watchdog.
// Accepted bytes go to a FIFO and toggle IRQ_KEYB.
module ps2_keyb
    import ps2_pkg::*;
#(
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic       RD,
    output logic [7:0] O_DATA,
    output logic       O_READY,
    output logic       IRQ_KEYB,
    output logic       O_OVF,
    output logic       O_PERR
);

    localparam int WW = $clog2(TIMEOUT + 1);

    logic          clk_s1_q, clk_s2_q, clk_prev_q;
    logic          dat_s1_q, dat_s2_q;
    logic          fall;

    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          perr_q, perr_d;
    logic          ovf_q, ovf_d;
    logic          irq_q, irq_d;

    logic          push_req;
    logic          fifo_empty;
    logic          fifo_full;
    logic          accept;

    assign fall = clk_prev_q & ~clk_s2_q;

    // Two-flop synchronizers plus edge-detect history; idle bus is high.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= PS2_CLK;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= PS2_DAT;
            dat_s2_q   <= dat_s1_q;
        end
    end

    // Frame FSM, watchdog and sticky status next-state.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        wdog_d    = wdog_q;
        perr_d    = perr_q;
        push_req  = 1'b0;

        if (fall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (dat_s2_q == START_BIT) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (dat_s2_q == STOP_BIT && odd_ok(shift_q, par_q)) begin
                        push_req = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (fall || state_q == ST_IDLE) begin
            wdog_d = '0;
        end else if (wdog_q == WW'(TIMEOUT)) begin
            wdog_d  = '0;
            state_d = ST_IDLE;
            perr_d  = 1'b1;
        end else begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    // A pop on a full FIFO makes room, so the byte is still taken.
    assign accept = push_req & (~fifo_full | RD);

    // Overflow and interrupt toggle follow the FIFO write decision.
    always_comb begin
        ovf_d = ovf_q | (push_req & fifo_full & ~RD);
        irq_d = irq_q ^ accept;
    end

    // Receiver state registers.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            wdog_q    <= '0;
            perr_q    <= 1'b0;
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            wdog_q    <= wdog_d;
            perr_q    <= perr_d;
            ovf_q     <= ovf_d;
            irq_q     <= irq_d;
        end
    end

    ps2_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk  (CLOCK),
        .rst_n(RESET_N),
        .push (push_req),
        .pop  (RD),
        .din  (shift_q),
        .dout (O_DATA),
        .empty(fifo_empty),
        .full (fifo_full)
    );

    assign O_READY  = ~fifo_empty;
    assign IRQ_KEYB = irq_q;
    assign O_OVF    = ovf_q;
    assign O_PERR   = perr_q;

endmodule

// File: tb/tb_ps2_keyb.sv
// Self-checking bench for ps2_keyb: directed scenarios plus
// randomized frames against a queue-based reference model.
module tb_ps2_keyb;
    import ps2_pkg::*;

    localparam int H  = 8;
    localparam int TO = 50000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ps2c  = 1'b1;
    logic ps2d  = 1'b1;

    ps2_keyb_if bus();

    always #5 clk = ~clk;

    ps2_keyb #(
        .TIMEOUT   (TO),
        .DEPTH_LOG2(3)
    ) dut (
        .CLOCK   (clk),
        .RESET_N (rst_n),
        .PS2_CLK (ps2c),
        .PS2_DAT (ps2d),
        .RD      (bus.rd),
        .O_DATA  (bus.data),
        .O_READY (bus.ready),
        .IRQ_KEYB(bus.irq),
        .O_OVF   (bus.ovf),
        .O_PERR  (bus.perr)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q[$];
    int         toggles;
    logic       m_ovf;
    logic       m_perr;
    logic       rd_at_stop = 1'b0;
    logic       chk_lat    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        q.delete();
        toggles = 0;
        m_ovf   = 1'b0;
        m_perr  = 1'b0;
    endtask

    task automatic do_reset();
        #3;
        rst_n  = 1'b0;
        ps2c   = 1'b1;
        ps2d   = 1'b1;
        bus.rd = 1'b0;
        tick(2);
        rst_n = 1'b1;
        model_clear();
        tick(2);
    endtask

    // Bits in line order: start, d0..d7, parity, stop.
    task automatic send(input logic [7:0] d, input logic pbad,
                        input logic stopb, input int nbits);
        logic [10:0] b;
        b[0]   = 1'b0;
        b[8:1] = d;
        b[9]   = ~(^d) ^ pbad;
        b[10]  = stopb;
        for (int i = 0; i < nbits; i++) begin
            ps2d = b[i];
            tick(H);
            ps2c = 1'b0;
            for (int k = 0; k < H; k++) begin
                tick(1);
                if (i == 10 && k == 1) begin
                    if (rd_at_stop) bus.rd = 1'b1;
                    if (chk_lat) chk("lat_pre", 32'(bus.ready), 0);
                end
                if (i == 10 && k == 2) begin
                    bus.rd = 1'b0;
                    if (chk_lat) chk("lat_post", 32'(bus.ready), 1);
                end
            end
            ps2c = 1'b1;
        end
        tick(H);
    endtask

    task automatic model_frame(input logic [7:0] d, input logic pbad,
                               input logic stopb);
        if (!pbad && stopb) begin
            if (q.size() < 8) begin
                q.push_back(d);
                toggles++;
            end else begin
                m_ovf = 1'b1;
            end
        end else begin
            m_perr = 1'b1;
        end
    endtask

    task automatic frame(input logic [7:0] d, input logic pbad,
                         input logic stopb);
        send(d, pbad, stopb, 11);
        model_frame(d, pbad, stopb);
    endtask

    task automatic pop();
        bus.rd = 1'b1;
        tick(1);
        bus.rd = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_rdy"}, 32'(bus.ready), 32'(q.size() != 0));
        if (q.size() != 0) chk({tag, "_data"}, 32'(bus.data), 32'(q[0]));
        chk({tag, "_irq"}, 32'(bus.irq), 32'(toggles % 2));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(m_ovf));
        chk({tag, "_perr"}, 32'(bus.perr), 32'(m_perr));
    endtask

    initial begin
        bus.rd = 1'b0;
        model_clear();
        do_reset();

        chk("rst_data", 32'(bus.data), 0);
        chk("rst_ready", 32'(bus.ready), 0);
        chk("rst_irq", 32'(bus.irq), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        chk("rst_perr", 32'(bus.perr), 0);

        chk_lat = 1'b1;
        frame(8'h1C, 1'b0, 1'b1);
        chk_lat = 1'b0;
        check_state("good1c");
        chk("good1c_val", 32'(bus.data), 32'h1C);

        pop();
        check_state("pop1c");
        frame(8'h1C, 1'b1, 1'b1);
        check_state("badpar");
        chk("badpar_perr", 32'(bus.perr), 1);

        do_reset();
        for (int i = 1; i <= 9; i++) frame(8'(i), 1'b0, 1'b1);
        check_state("ovf9");
        chk("ovf9_flag", 32'(bus.ovf), 1);
        chk("ovf9_tog", 32'(toggles), 8);
        for (int i = 1; i <= 8; i++) begin
            chk("ovf9_pop", 32'(bus.data), 32'(i));
            pop();
        end
        check_state("ovf9_end");

        do_reset();
        send(8'h05, 1'b0, 1'b1, 4);
        tick(TO + 20);
        m_perr = 1'b1;
        check_state("tmo");
        frame(8'hF0, 1'b0, 1'b1);
        check_state("tmo_f0");
        chk("tmo_f0_val", 32'(bus.data), 32'hF0);

        do_reset();
        for (int i = 0; i < 8; i++) frame(8'h10 + 8'(i), 1'b0, 1'b1);
        rd_at_stop = 1'b1;
        send(8'hAA, 1'b0, 1'b1, 11);
        rd_at_stop = 1'b0;
        void'(q.pop_front());
        q.push_back(8'hAA);
        toggles++;
        check_state("fullrd");
        chk("fullrd_ovf", 32'(bus.ovf), 0);
        for (int i = 0; i < 8; i++) begin
            check_state("fullrd_pop");
            pop();
        end
        check_state("fullrd_end");

        do_reset();
        send(8'h33, 1'b0, 1'b1, 6);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        model_clear();
        tick(2);
        frame(8'h5A, 1'b0, 1'b1);
        check_state("rst5a");
        chk("rst5a_val", 32'(bus.data), 32'h5A);
        chk("rst5a_irq", 32'(bus.irq), 1);
        pop();
        check_state("rst5a_end");

        do_reset();
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            logic       pb;
            logic       sb;
            int         np;
            d  = 8'($urandom);
            pb = ($urandom_range(0, 5) == 0);
            sb = ($urandom_range(0, 7) != 0);
            frame(d, pb, sb);
            check_state("rnd");
            np = $urandom_range(0, 2);
            for (int j = 0; j < np; j++) begin
                pop();
                check_state("rnd_pop");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
